// File: rtl/width_8to12_arb_if.sv
// -----------------------------------------------------------------------------
// width_8to12_arb_if
//   Bundles the requester-side byte streams, the converter feed and the
//   grant/owner status of width_8to12_arb.
//   slave  : used by the arbiter (takes requests, drives converter/status)
//   master : used by requesters/environment (drives requests)
//   Signals:
//     req_valid   [N_REQ]         per-requester byte valid
//     req_data    [N_REQ*DATA_W]  per-requester byte, requester i at [i*8+:8]
//     req_ready   [N_REQ]         byte accepted this cycle
//     conv_valid / conv_data      feed to the 8->12 converter
//     gnt_onehot  [N_REQ]         registered grant
//     busy                        grant held
//     owner_valid / owner_id      owner tag aligned with converter valid_out
// -----------------------------------------------------------------------------
interface width_8to12_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    conv_valid;
  logic [DATA_W-1:0]       conv_data;
  logic [N_REQ-1:0]        gnt_onehot;
  logic                    busy;
  logic                    owner_valid;
  logic [IDX_W-1:0]        owner_id;

  modport slave (
    input  req_valid, req_data,
    output req_ready, conv_valid, conv_data, gnt_onehot, busy,
           owner_valid, owner_id
  );

  modport master (
    output req_valid, req_data,
    input  req_ready, conv_valid, conv_data, gnt_onehot, busy,
           owner_valid, owner_id
  );
endinterface

// File: rtl/width_8to12_arb.sv
// -----------------------------------------------------------------------------
// width_8to12_arb
//   Round-robin scheduler sharing one stateful 8->12 width converter between
//   N_REQ byte-stream requesters. Grants are atomic per 3-byte group and are
//   forcibly rotated after MAX_GROUPS groups. Also produces an owner tag that
//   lines up with the converter's valid_out.
//   Ports:
//     clk    clock
//     rst_n  async active-low reset (shared with the converter)
//     bus    width_8to12_arb_if.slave (requests in, converter feed and
//            grant/owner status out)
// -----------------------------------------------------------------------------
module width_8to12_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_GROUPS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  width_8to12_arb_if.slave   bus
);

  localparam int          IDX_W = $clog2(N_REQ);
  localparam int          GRP_W = (MAX_GROUPS > 1) ? $clog2(MAX_GROUPS) : 1;
  localparam int unsigned NR    = N_REQ;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [GRP_W-1:0] grp_cnt_q, grp_cnt_d;
  logic             owner_valid_q, owner_valid_d;
  logic [IDX_W-1:0] owner_id_q, owner_id_d;

  logic             busy;
  logic             conv_valid;
  logic [N_REQ-1:0] ready;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] cand;

  assign busy       = (state_q == BUSY);
  assign conv_valid = busy & bus.req_valid[gnt_q];

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      ready[i] = busy & (gnt_q == IDX_W'(i));
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NR);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    gnt_oh_d   = gnt_oh_q;
    byte_cnt_d = byte_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    // Converter emits a word one cycle after bytes 2 and 3 of each group.
    owner_valid_d = conv_valid && (byte_cnt_q != 2'd0);
    owner_id_d    = owner_valid_d ? gnt_q : owner_id_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick;
          last_d   = pick;
          gnt_oh_d = N_REQ'(1) << pick;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (conv_valid) begin
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = '0;
            if (grp_cnt_q == GRP_W'(MAX_GROUPS - 1)) begin
              grp_cnt_d = '0;
              gnt_oh_d  = '0;
              state_d   = IDLE;
            end else begin
              grp_cnt_d = grp_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (byte_cnt_q == 2'd0) begin
          // Voluntary release only at a group boundary; mid-group we stall.
          grp_cnt_d = '0;
          gnt_oh_d  = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_q        <= IDX_W'(N_REQ - 1);
      gnt_oh_q      <= '0;
      byte_cnt_q    <= '0;
      grp_cnt_q     <= '0;
      owner_valid_q <= 1'b0;
      owner_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      gnt_oh_q      <= gnt_oh_d;
      byte_cnt_q    <= byte_cnt_d;
      grp_cnt_q     <= grp_cnt_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.conv_valid  = conv_valid;
  assign bus.conv_data   = bus.req_data[32'(gnt_q)*DATA_W +: DATA_W];
  assign bus.gnt_onehot  = gnt_oh_q;
  assign bus.busy        = busy;
  assign bus.owner_valid = owner_valid_q;
  assign bus.owner_id    = owner_id_q;

endmodule

// File: tb/tb_width_8to12_arb.sv
// -----------------------------------------------------------------------------
// tb_width_8to12_arb
//   Requesters hold queues of whole 3-byte groups; every group pushes its two
//   expected 12-bit words into that requester's scoreboard queue. A monitor
//   models the downstream converter from conv_valid/conv_data and, whenever a
//   word comes out, pops the queue selected by owner_id and compares.
// -----------------------------------------------------------------------------
module tb_width_8to12_arb;

  localparam int N  = 4;
  localparam int MG = 2;

  logic clk;
  logic rst_n;

  width_8to12_arb_if #(.N_REQ(N), .DATA_W(8)) bus ();

  width_8to12_arb #(.N_REQ(N), .DATA_W(8), .MAX_GROUPS(MG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  byte_q [N][$];
  logic [11:0] exp_q  [N][$];
  logic [N-1:0] stall;
  logic [N-1:0] acc;
  int gap_pct;
  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Two 12-bit words per 3-byte group: {a, b_hi} then {b_lo, c}.
  task automatic push_group(input int r, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
    byte_q[r].push_back(a);
    byte_q[r].push_back(b);
    byte_q[r].push_back(c);
    exp_q[r].push_back(12'((a * 16) + (b / 16)));
    exp_q[r].push_back(12'(((b % 16) * 256) + c));
  endtask

  task automatic push_rand_group(input int r);
    push_group(r, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // One clock of requester behaviour; returns at negedge+1 with inputs settled.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i] && byte_q[i].size() > 0) void'(byte_q[i].pop_front());
    end
    acc = '0;
    for (int i = 0; i < N; i++) begin
      logic v;
      v = (byte_q[i].size() > 0) && !stall[i];
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) v = 1'b0;
      bus.req_valid[i] = v;
      bus.req_data[i*8 +: 8] = (byte_q[i].size() > 0) ? byte_q[i][0] : 8'h00;
    end
    #1;
    acc = bus.req_valid & bus.req_ready;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) begin
      if (byte_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"},        32'(bus.gnt_onehot),  32'h0);
    chk({tag, "_busy"},       32'(bus.busy),        32'h0);
    chk({tag, "_owner_vld"},  32'(bus.owner_valid), 32'h0);
    chk({tag, "_owner_id"},   32'(bus.owner_id),    32'h0);
    chk({tag, "_ready"},      32'(bus.req_ready),   32'h0);
    chk({tag, "_conv_valid"}, 32'(bus.conv_valid),  32'h0);
  endtask

  // Called at negedge+1; asserts reset asynchronously, checks, then releases.
  task automatic do_reset(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs(tag);
    for (int i = 0; i < N; i++) begin
      byte_q[i].delete();
      exp_q[i].delete();
    end
    acc = '0;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_drained(input string name, input int max_cyc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      step();
      n++;
      chk("ready_vs_gnt", 32'(bus.req_ready), bus.busy ? 32'(bus.gnt_onehot) : 32'h0);
      chk("gnt_onehot", 32'($countones(bus.gnt_onehot)), 32'(bus.busy));
      done = all_empty() && !bus.busy;
    end
    chk(name, 32'(done), 32'h1);
  endtask

  // Downstream converter model + scoreboard checker.
  initial begin : monitor
    logic [7:0]  m_b0;
    logic [3:0]  m_lo;
    logic [11:0] pend_w;
    logic [7:0]  d;
    int          ph;
    bit          pend;
    int          id;
    ph = 0;
    pend = 1'b0;
    m_b0 = '0;
    m_lo = '0;
    pend_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ph = 0;
        pend = 1'b0;
      end else begin
        chk("owner_align", 32'(bus.owner_valid), 32'(pend));
        if (pend && bus.owner_valid) begin
          id = int'(bus.owner_id);
          if (exp_q[id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL word_unexpected: got %0h for owner %0d expected no word", pend_w, id);
          end else begin
            chk($sformatf("word_req%0d", id), 32'(pend_w), 32'(exp_q[id].pop_front()));
          end
        end
        pend = 1'b0;
      end
      #1;
      if (rst_n && bus.conv_valid) begin
        d = bus.conv_data;
        case (ph)
          0: begin m_b0 = d; ph = 1; end
          1: begin pend_w = {m_b0, d[7:4]}; m_lo = d[3:0]; pend = 1'b1; ph = 2; end
          default: begin pend_w = {m_lo, d}; pend = 1'b1; ph = 0; end
        endcase
      end
    end
  end

  initial begin : stimulus
    int exp_oh;
    bit exp_busy;
    bit seen;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    stall   = '0;
    acc     = '0;
    gap_pct = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, back-to-back, two groups.
    push_group(0, 8'h12, 8'h34, 8'h56);
    push_group(0, 8'h78, 8'h9A, 8'hBC);
    step();
    chk("t1_idle_cycle_busy", 32'(bus.busy), 32'h0);
    chk("t1_idle_cycle_conv", 32'(bus.conv_valid), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_gnt", 32'(bus.gnt_onehot), 32'h1);
      chk("t1_b2b_conv_valid", 32'(bus.conv_valid), 32'h1);
    end
    step();
    chk("t1_idle_after", 32'(bus.busy), 32'h0);
    run_until_drained("t1_drain", 20);

    // Forced rotation between two always-valid requesters.
    do_reset("rst2");
    for (int g = 0; g < 2 * MG; g++) begin
      push_rand_group(0);
      push_rand_group(1);
    end
    step();
    for (int k = 1; k <= 27; k++) begin
      step();
      exp_busy = (k % (3 * MG + 1)) != 0;
      exp_oh   = !exp_busy ? 0 : (((k / (3 * MG + 1)) % 2) == 0 ? 1 : 2);
      chk($sformatf("t2_busy_k%0d", k), 32'(bus.busy), 32'(exp_busy));
      chk($sformatf("t2_gnt_k%0d", k), 32'(bus.gnt_onehot), 32'(exp_oh));
    end
    run_until_drained("t2_drain", 40);

    // Mid-group stall holds the grant; other requester waits.
    do_reset("rst3");
    push_rand_group(1);
    step();
    step();
    chk("t3_gnt_req1", 32'(bus.gnt_onehot), 32'h2);
    stall[1] = 1'b1;
    push_rand_group(0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold_gnt", 32'(bus.gnt_onehot), 32'h2);
      chk("t3_req0_not_ready", 32'(bus.req_ready[0]), 32'h0);
      chk("t3_no_byte", 32'(bus.conv_valid), 32'h0);
    end
    stall[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      seen = (bus.gnt_onehot == 4'b0001);
    end
    chk("t3_req0_after", 32'(seen), 32'h1);
    run_until_drained("t3_drain", 20);

    // Random interleaved traffic, first requesters 1 and 3, then all.
    gap_pct = 30;
    for (int g = 0; g < int'($urandom_range(2, 5)); g++) push_rand_group(1);
    for (int g = 0; g < int'($urandom_range(2, 5)); g++) push_rand_group(3);
    run_until_drained("t6_drain_13", 2000);
    for (int r = 0; r < N; r++) begin
      for (int g = 0; g < int'($urandom_range(1, 4)); g++) push_rand_group(r);
    end
    run_until_drained("t6_drain_all", 3000);
    gap_pct = 0;

    // Reset mid-group, then priority from the reset pointer.
    push_rand_group(0);
    step();
    step();
    step();
    step();
    do_reset("rst_midgroup");
    push_rand_group(0);
    push_rand_group(2);
    step();
    step();
    chk("t4_first_pick", 32'(bus.gnt_onehot), 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      seen = (bus.gnt_onehot == 4'b0100);
    end
    chk("t4_next_req2", 32'(seen), 32'h1);
    run_until_drained("t5_drain", 20);

    repeat (3) step();
    chk("scoreboard_empty", 32'(all_empty()), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
